// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for product_accumulator and its adder.
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int unsigned PROD_W   = 8;
    localparam int unsigned PROD_MAX = 225;

endpackage

// File: rtl/product_accumulator_acc_add.sv
// ACC_W-wide accumulate adder; PRODUCT_ACCUMULATOR_SATURATE_EN selects clamp-to-ones
// with an overflow flag, otherwise the sum wraps and ovf is 0.
module acc_add
    import product_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    logic [ACC_W:0] wide;

    always_comb begin
        wide = {1'b0, acc} + (ACC_W + 1)'(prod);
        ovf  = wide[ACC_W];
        sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    end
`else
    always_comb begin
        sum = acc + ACC_W'(prod);
        ovf = 1'b0;
    end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Valid/ready multiply-accumulate stage: sums up to VEC_LEN products per result.
// Overflow behaviour is selected by PRODUCT_ACCUMULATOR_SATURATE_EN (see acc_add).
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter  int unsigned VEC_LEN = 8,
    parameter  int unsigned ACC_W   = 16,
    localparam int unsigned CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt;
    logic             ovf_next;
    logic             ovf_vec;
    logic             xfer;
    logic             term;

    acc_add #(.ACC_W(ACC_W)) u_add (
        .acc  (acc),
        .prod (in_product),
        .sum  (sum_next),
        .ovf  (ovf_next)
    );

    // in_last only matters when qualified by a transfer
    always_comb begin
        xfer = in_valid && in_ready;
        term = (cnt == CNT_W'(VEC_LEN - 1)) || in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf_vec   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: begin
                    if (xfer) begin
                        acc     <= sum_next;
                        cnt     <= cnt + CNT_W'(1);
                        ovf_vec <= ovf_vec | ovf_next;
                        if (term) begin
                            out_sum   <= sum_next;
                            out_count <= cnt + CNT_W'(1);
                            out_ovf   <= ovf_vec | ovf_next;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_ovf   <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf_vec   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a default instance and a narrow
// ACC_W=8/VEC_LEN=2 instance for the overflow cases.
module tb_product_accumulator;

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
        int unsigned ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_product = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [3:0]  out_count;
    logic        out_ovf;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_in_product = '0;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_out_sum;
    logic [1:0]  s_out_count;
    logic        s_out_ovf;

    exp_t q_main[$];
    exp_t q_small[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    product_accumulator #(.VEC_LEN(8), .ACC_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    product_accumulator #(.VEC_LEN(2), .ACC_W(8)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_product (s_in_product),
        .in_last    (s_in_last),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_sum    (s_out_sum),
        .out_count  (s_out_count),
        .out_ovf    (s_out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_main(input int unsigned s, input int unsigned c, input int unsigned o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        q_main.push_back(e);
    endtask

    task automatic push_small(input int unsigned s, input int unsigned c, input int unsigned o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        q_small.push_back(e);
    endtask

    // Monitors: compare whenever a result is handed off
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: got result sum %0d expected no result", out_sum);
            end else begin
                e = q_main.pop_front();
                check("main_sum", 32'(out_sum), e.sum);
                check("main_count", 32'(out_count), e.cnt);
                check("main_ovf", 32'(out_ovf), e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s_out_valid && s_out_ready) begin
            if (q_small.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL small_unexpected: got result sum %0d expected no result", s_out_sum);
            end else begin
                e = q_small.pop_front();
                check("small_sum", 32'(s_out_sum), e.sum);
                check("small_count", 32'(s_out_count), e.cnt);
                check("small_ovf", 32'(s_out_ovf), e.ovf);
            end
        end
    end

    task automatic send(input logic [7:0] p, input logic l);
        int n = 0;
        in_valid = 1'b1; in_product = p; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_product = 'x; in_last = 'x;
    endtask

    task automatic send_s(input logic [7:0] p, input logic l);
        int n = 0;
        s_in_valid = 1'b1; s_in_product = p; s_in_last = l;
        @(negedge clk);
        while (!s_in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_s_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0; s_in_product = 'x; s_in_last = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_main.size() != 0 || q_small.size() != 0) && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_pending", 32'(q_main.size() + q_small.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [7:0] vec1 [8];
        vec1 = '{8'd6, 8'd20, 8'd42, 8'd72, 8'd110, 8'd156, 8'd210, 8'd0};

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        check("rst_s_in_ready", 32'(s_in_ready), 0);
        check("rst_s_out_valid", 32'(s_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rel_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("post_rel_in_ready_high", 32'(in_ready), 1);

        // Full vector, back-to-back
        out_ready = 1'b1;
        push_main(616, 8, 0);
        foreach (vec1[i]) send(vec1[i], 1'b0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("full_in_ready_back", 32'(in_ready), 1);
        check("full_out_valid_clr", 32'(out_valid), 0);
        drain();

        // Early termination with bubbles
        push_main(68, 3, 0);
        send(8'd6, 1'b0);
        idle(2);
        send(8'd20, 1'b0);
        idle(2);
        send(8'd42, 1'b1);
        drain();

        // Backpressure
        out_ready = 1'b0;
        push_main(60, 3, 0);
        push_main(100, 2, 0);
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b1);
        in_valid = 1'b1; in_product = 8'd99; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_sum", 32'(out_sum), 60);
            check("bp_out_count", 32'(out_count), 3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd99, 1'b0);
        send(8'd1, 1'b1);
        drain();

        // Overflow on the narrow instance
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        push_small(255, 2, 1);
`else
        push_small(164, 2, 0);
`endif
        push_small(2, 2, 0);
        send_s(8'd210, 1'b0);
        send_s(8'd210, 1'b0);
        send_s(8'd1, 1'b0);
        send_s(8'd1, 1'b0);
        drain();

        // Reset mid-vector
        repeat (3) send(8'd225, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_sum", 32'(out_sum), 0);
        check("mid_rst_out_count", 32'(out_count), 0);
        check("mid_rst_out_ovf", 32'(out_ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_main(8, 8, 0);
        repeat (8) send(8'd1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
